// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: control FSM state, stage-control bundle and register-address width.
package cpu_types_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CtlAdvance = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0
  };

  localparam pipe_ctl_t CtlFreeze = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic                idex_dren_i,
  input  logic [RegAddrW-1:0] idex_rt_i,
  input  logic [RegAddrW-1:0] ifid_rs_i,
  input  logic [RegAddrW-1:0] ifid_rt_i,
  output logic                load_use_o
);

  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use_o = idex_dren_i && (idex_rt_i != '0) &&
                 ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with data-wait watchdog and halt latch.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                dmemreq,
  input  logic                idex_DRen,
  input  logic [RegAddrW-1:0] idex_Rt,
  input  logic [RegAddrW-1:0] ifid_Rs,
  input  logic [RegAddrW-1:0] ifid_Rt,
  input  logic                brtaken,
  input  logic                halt_i,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ieen,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                halt_o,
  output logic                err_timeout,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] WaitLimit = CntW'(WAIT_LIMIT);

  pipe_state_t     state_q, state_d;
  pipe_ctl_t       ctl;
  logic            load_use;
  logic            data_freeze;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;

  hazard_detect u_hazard_detect (
    .idex_dren_i (idex_DRen),
    .idex_rt_i   (idex_Rt),
    .ifid_rs_i   (ifid_Rs),
    .ifid_rt_i   (ifid_Rt),
    .load_use_o  (load_use)
  );

  // A freeze in DWAIT lifts in the same cycle dhit arrives.
  always_comb begin
    data_freeze = 1'b0;
    unique case (state_q)
      RUN:     data_freeze = dmemreq && !dhit;
      DWAIT:   data_freeze = !dhit;
      default: data_freeze = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_i) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        RUN:     state_d = data_freeze ? DWAIT : RUN;
        DWAIT:   state_d = dhit ? RUN : DWAIT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // Freeze outranks everything, so flushes never leak out while stages are held.
  always_comb begin
    ctl = CtlAdvance;
    if ((state_q == HALT) || data_freeze) begin
      ctl = CtlFreeze;
    end else if (brtaken) begin
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
    end else if (load_use) begin
      ctl.pc_en      = 1'b0;
      ctl.ifid_en    = 1'b0;
      ctl.idex_flush = 1'b1;
    end else if (!ihit) begin
      ctl.pc_en      = 1'b0;
      ctl.ifid_flush = 1'b1;
    end
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign ieen       = ctl.idex_en;
  assign exmem_en   = ctl.exmem_en;
  assign memwb_en   = ctl.memwb_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;
  assign halt_o     = (state_q == HALT);

  // Counter saturates at the limit so a long wait cannot wrap back below it.
  always_comb begin
    wait_cnt_d = '0;
    if (state_d == DWAIT) begin
      wait_cnt_d = (wait_cnt_q == WaitLimit) ? wait_cnt_q : wait_cnt_q + CntW'(1);
    end
    err_d = err_q || ((state_d == DWAIT) && (wait_cnt_d == WaitLimit));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctl.pc_en && (state_q != HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (ctl.idex_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; control word order {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl}.
module tb_pipe_ctrl;

  localparam logic [6:0] Norm = 7'b1111100;
  localparam logic [6:0] Frz  = 7'b0000000;
  localparam logic [6:0] Br   = 7'b1111111;
  localparam logic [6:0] Lu   = 7'b0011101;
  localparam logic [6:0] Miss = 7'b0111110;
`ifdef PIPE_PERF_EN
  localparam logic [31:0] ExpStall = 32'd3;
  localparam logic [31:0] ExpFlush = 32'd1;
`else
  localparam logic [31:0] ExpStall = 32'd0;
  localparam logic [31:0] ExpFlush = 32'd0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, dmemreq, idex_DRen, brtaken, halt_i;
  logic [4:0]  idex_Rt, ifid_Rs, ifid_Rt;
  logic        pc_en, ifid_en, ieen, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic        halt_o, err_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctl;

  int total = 0;
  int bad   = 0;

  assign ctl = {pc_en, ifid_en, ieen, exmem_en, memwb_en, ifid_flush, idex_flush};

  always #5 CLK = ~CLK;

  pipe_ctrl #(.WAIT_LIMIT(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .dmemreq     (dmemreq),
    .idex_DRen   (idex_DRen),
    .idex_Rt     (idex_Rt),
    .ifid_Rs     (ifid_Rs),
    .ifid_Rt     (ifid_Rt),
    .brtaken     (brtaken),
    .halt_i      (halt_i),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ieen        (ieen),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .halt_o      (halt_o),
    .err_timeout (err_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; dmemreq = 1'b0; idex_DRen = 1'b0; brtaken = 1'b0;
    halt_i = 1'b0; idex_Rt = 5'd0; ifid_Rs = 5'd0; ifid_Rt = 5'd0;
  endtask

  // Move to the next cycle's drive point, just after the rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    chk("reset_ctl", {25'd0, ctl}, {25'd0, Norm});
    chk("reset_halt", {31'd0, halt_o}, 32'd0);
    chk("reset_err", {31'd0, err_timeout}, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_flush", flush_cnt, 32'd0);
    next_cycle();
    RST = 1'b0;
    next_cycle();

    // Three instruction misses then one taken branch.
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("imiss_ctl", {25'd0, ctl}, {25'd0, Miss});
      next_cycle();
    end
    ihit = 1'b1; brtaken = 1'b1;
    @(negedge CLK);
    chk("branch_ctl", {25'd0, ctl}, {25'd0, Br});
    next_cycle();
    brtaken = 1'b0;
    @(negedge CLK);
    chk("perf_stall", stall_cnt, ExpStall);
    chk("perf_flush", flush_cnt, ExpFlush);
    next_cycle();

    // Load-use via Rs, then cleared the next cycle.
    idex_DRen = 1'b1; idex_Rt = 5'd8; ifid_Rs = 5'd8;
    @(negedge CLK);
    chk("loaduse_rs", {25'd0, ctl}, {25'd0, Lu});
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk("loaduse_once", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    idex_DRen = 1'b1; idex_Rt = 5'd9; ifid_Rs = 5'd3; ifid_Rt = 5'd9;
    @(negedge CLK);
    chk("loaduse_rt", {25'd0, ctl}, {25'd0, Lu});
    idex_Rt = 5'd0; ifid_Rs = 5'd0; ifid_Rt = 5'd0;
    #1;
    chk("loaduse_r0", {25'd0, ctl}, {25'd0, Norm});
    idex_DRen = 1'b0; idex_Rt = 5'd8; ifid_Rs = 5'd8;
    #1;
    chk("noload", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();

    // Branch overrides load-use and ihit miss.
    idex_DRen = 1'b1; idex_Rt = 5'd8; ifid_Rs = 5'd8; brtaken = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    chk("overlap_ctl", {25'd0, ctl}, {25'd0, Br});
    next_cycle();
    idle_inputs();

    // Data miss for 5 cycles; branch during the freeze must not flush.
    dmemreq = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      brtaken = (i == 2);
      @(negedge CLK);
      chk("dmiss_frz", {25'd0, ctl}, {25'd0, Frz});
      next_cycle();
    end
    brtaken = 1'b0; dhit = 1'b1;
    @(negedge CLK);
    chk("dmiss_release", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    dmemreq = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    chk("dmiss_back_run", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    idle_inputs();
    do_reset();

    // Watchdog at limit 4: first visible in dhit-low cycle 4 (counting from 0).
    dmemreq = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("wd_err", {31'd0, err_timeout}, (i >= 4) ? 32'd1 : 32'd0);
      chk("wd_frz", {25'd0, ctl}, {25'd0, Frz});
      next_cycle();
    end
    dhit = 1'b1; dmemreq = 1'b0;
    @(negedge CLK);
    chk("wd_sticky", {31'd0, err_timeout}, 32'd1);
    chk("wd_run_ctl", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    idle_inputs();
    do_reset();

    // Reset mid-DWAIT abandons the wait.
    dmemreq = 1'b1; dhit = 1'b0;
    next_cycle();
    next_cycle();
    dmemreq = 1'b0;
    @(negedge CLK);
    chk("dwait_held", {25'd0, ctl}, {25'd0, Frz});
    RST = 1'b1;
    #1;
    chk("dwait_rst_ctl", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    chk("dwait_post_rst", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    idle_inputs();

    // Halt pulse, then asynchronous reset mid-cycle.
    halt_i = 1'b1;
    next_cycle();
    halt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("halt_o", {31'd0, halt_o}, 32'd1);
      chk("halt_ctl", {25'd0, ctl}, {25'd0, Frz});
      next_cycle();
    end
    #1;
    RST = 1'b1;
    #1;
    chk("halt_rst_o", {31'd0, halt_o}, 32'd0);
    chk("halt_rst_ctl", {25'd0, ctl}, {25'd0, Norm});
    next_cycle();
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 64, the data-wait watchdog threshold in cycles.
REQ-002 SHALL have port CLK  in  1  pipeline clock.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ihit, dhit  in  1  instruction / data memory ready.
REQ-005 SHALL have port dmemreq  in  1  MEM stage holds a load or store (EX/MEM DRen_o|DWen_o).
REQ-006 SHALL have ports idex_DRen, idex_Rt  in  1, 5  load in EX and its destination register.
REQ-007 SHALL have ports ifid_Rs, ifid_Rt  in  5, 5  source registers of the instruction in ID.
REQ-008 SHALL have port brtaken  in  1  branch or jump resolved taken in EX.
REQ-009 SHALL have port halt_i  in  1  halt has reached MEM/WB.
REQ-010 SHALL have ports pc_en, ifid_en, ieen, exmem_en, memwb_en  out  1  stage latch enables.
REQ-011 SHALL have ports ifid_flush, idex_flush  out  1  load a bubble into the latch.
REQ-012 SHALL have ports halt_o, err_timeout  out  1  sticky status.
REQ-013 SHALL have ports stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-014 SHALL implement states RUN, DWAIT, HALT, held in a registered state variable.
REQ-015 SHALL drive enables and flushes combinationally from the state and the current inputs.
REQ-016 In RUN with dmemreq=1 and dhit=0, SHALL drive all enables and flushes to 0 and go to DWAIT.
REQ-017 In DWAIT, SHALL freeze all stages and stay there until dhit=1, then behave as RUN in that same cycle and return to RUN next.
REQ-018 Branch: brtaken=1 outside a freeze SHALL assert ifid_flush=1, idex_flush=1 and pc_en=1, regardless of ihit.
REQ-019 Load-use: idex_DRen=1, idex_Rt!=0, and idex_Rt equal to ifid_Rs or ifid_Rt, SHALL give pc_en=0, ifid_en=0, idex_flush=1, with later stages enabled.
REQ-020 ihit=0 (no freeze, branch or load-use) SHALL give pc_en=0, ifid_flush=1, with later stages enabled.
REQ-021 Priority SHALL be HALT > data freeze > branch > load-use > ihit miss > normal advance (all enables 1, flushes 0).
REQ-022 halt_i=1 in any state SHALL move to HALT next cycle.
REQ-023 In HALT, all enables SHALL be 0 and halt_o SHALL be 1 until reset.
REQ-024 A wait counter SHALL count cycles spent in DWAIT and clear on leaving DWAIT.
REQ-025 When the wait counter reaches WAIT_LIMIT, err_timeout SHALL set and remain set until reset; state and enables are unaffected.
REQ-026 A flush asserted in the same cycle as a freeze SHALL be suppressed.

Reset
REQ-027 RST=1 SHALL force state RUN, wait counter 0, halt_o=0, err_timeout=0 and both counters 0, immediately and without waiting for CLK.
REQ-028 Reset mid-DWAIT SHALL abandon the wait; enables reflect RUN as soon as RST deasserts.

Configuration
REQ-029 With PIPE_PERF_EN defined, stall_cnt SHALL add 1 per cycle with pc_en=0 outside HALT.
REQ-030 With PIPE_PERF_EN defined, flush_cnt SHALL add 1 per cycle with idex_flush=1.
REQ-031 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-032 Without PIPE_PERF_EN, both counters SHALL be constant 0 and no counter flops shall be synthesized.

Structure
REQ-033 The pipe_state_t enum (RUN, DWAIT, HALT) SHALL be added to cpu_types_pkg.
REQ-034 The load-use comparison SHALL be a combinational sub-module, hazard_detect.

Verification
REQ-035 Load-use: idex_DRen=1, idex_Rt=8, ifid_Rs=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for exactly that cycle.
REQ-036 Data miss: dmemreq=1, dhit=0 for 5 cycles, then dhit=1 -> all enables 0 for 5 cycles; advance on the dhit cycle; RUN next cycle.
REQ-037 Overlap: brtaken=1 with the REQ-035 load-use inputs -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-038 Watchdog: WAIT_LIMIT=4, dhit held 0 for 6 cycles -> err_timeout rises on cycle 4 and stays 1 after dhit=1.
REQ-039 Halt then reset: halt_i=1 pulse -> halt_o=1 and enables 0 indefinitely; RST=1 mid-cycle -> halt_o=0 immediately.
REQ-040 Perf: PIPE_PERF_EN defined, 3 ihit-miss cycles plus 1 branch -> stall_cnt=3, flush_cnt=1; macro undefined -> both read 0.
